el2_lsu_ecc_mbank: RTL and testbench
====================================

Name: el2_lsu_ecc_mbank

Overview:
Parametrised multi-bank DCCM SECDED checker/corrector for the LSU. It replaces the fixed hi/lo pair with NUM_BANKS independent 32-bit banks and a selectable registered result stage. It adds a correction write-back engine with a one-entry buffer and valid/ready handshake, plus saturating single/double error counters with a threshold flag. It sits between the DCCM read port and the LSU bus/DCCM write arbiter.

Parameters:
NUM_BANKS, 2, number of 32-bit DCCM banks checked per access (1..8)
ADDR_WIDTH, 16, DCCM address width
CNT_WIDTH, 16, width of each error counter
PIPE_STAGE, 1, 0 = combinational check results, 1 = results registered one cycle

Ports:
clk  in  1  core clock
rst_l  in  1  async reset, active low
ecc_disable  in  1  suppresses all checking, correction and counting
rd_valid  in  1  DCCM read data valid this cycle
rd_addr  in  ADDR_WIDTH  access address
rd_bank_en  in  NUM_BANKS  banks taking part in the access
rd_data  in  32*NUM_BANKS  raw bank data, bank i at [32i+31:32i]
rd_ecc  in  7*NUM_BANKS  stored check bits, bank i at [7i+6:7i]
res_valid  out  1  check result valid
sec_data  out  32*NUM_BANKS  corrected data
single_err  out  NUM_BANKS  per-bank single-bit error
double_err  out  1  any enabled bank has an uncorrectable error
wb_valid  out  1  correction write-back request
wb_ready  in  1  write-back accepted
wb_addr  out  ADDR_WIDTH  write-back address
wb_mask  out  NUM_BANKS  banks to rewrite
wb_data  out  32*NUM_BANKS  corrected data to write
wb_ecc  out  7*NUM_BANKS  regenerated check bits
wb_drop  out  1  sticky: a correction was dropped
cnt_clear  in  1  clears counters and wb_drop
err_thresh  in  CNT_WIDTH  single-error threshold; 0 disables the flag
err_cnt_single  out  CNT_WIDTH  saturating single-error access count
err_cnt_double  out  CNT_WIDTH  saturating double-error access count
err_thresh_hit  out  1  registered flag: err_cnt_single >= err_thresh and err_thresh != 0

Behaviour:
- Reset (async, rst_l=0):
  - All registered outputs, counters, wb_drop and err_thresh_hit go to 0.
  - FSM goes to IDLE.
  - An in-flight write-back is abandoned: wb_valid drops immediately.
- Decode:
  - One rvecc_decode per bank (sed_ded=0); enable = rd_valid & rd_bank_en[i] & ~ecc_disable.
  - Banks that are not enabled report no error, and their sec_data equals rd_data.
- Result timing:
  - PIPE_STAGE=0: res_valid=rd_valid, same cycle.
  - PIPE_STAGE=1: res_valid, sec_data, single_err and double_err are flopped, 1 cycle after rd_valid.
- Eligible correction: res_valid & |single_err & ~double_err.
- Double-error precedence: any double error suppresses the write-back and the single-error count for that access.
- Counters:
  - Each result cycle with an eligible correction adds 1 to err_cnt_single.
  - Each result cycle with double_err adds 1 to err_cnt_double.
  - Both counters saturate at all-ones.
  - cnt_clear has priority over an increment in the same cycle.
  - err_thresh_hit is updated one cycle after the counter update.
- Write-back FSM:
  - IDLE, eligible correction: capture address, wb_mask=single_err, sec_data, and wb_ecc = rvecc_encode(sec_data) per bank. Go to WB. wb_valid=1 in the next cycle.
  - WB: hold all wb_* outputs stable until wb_valid & wb_ready, then return to IDLE.
  - WB, handshake completes and an eligible correction arrives in the same cycle: capture the new one and stay in WB. wb_valid stays 1.
  - WB, no handshake and an eligible correction arrives: drop it and set wb_drop. wb_drop stays set until cnt_clear.
- ecc_disable: does not cancel a pending write-back; it only blocks new captures.

Test Plan:
- PIPE_STAGE=1, NUM_BANKS=2, rd_data all 0, rd_ecc all 0, both banks enabled -> one cycle later res_valid=1, single_err=0, double_err=0, no wb_valid.
- Bank1 data 32'h0000_0001, ecc 0 -> sec_data bank1=0, single_err=2'b10, err_cnt_single=1. Next cycle wb_valid=1, wb_mask=2'b10, wb_data bank1=0, wb_ecc bank1=7'h0. It holds until wb_ready.
- Bank0 data 32'h0000_0003, ecc 0 -> double_err=1, err_cnt_double=1, no wb_valid, err_cnt_single unchanged.
- wb_ready=0 while in WB and a second single error arrives -> wb_drop=1 and the first request is unchanged. Then raise wb_ready while a third single error arrives in the same cycle -> wb_valid stays 1 with the third address.
- err_thresh=3, three single-error accesses -> err_thresh_hit=1 one cycle after the count reaches 3. cnt_clear -> counters=0, wb_drop=0, flag=0 next cycle.
- Assert rst_l=0 while wb_valid=1 -> wb_valid=0 immediately. ecc_disable=1 with a single-bit flip -> no error, no count, sec_data=raw data.

Source files
------------

// File: rtl/el2_lsu_ecc_mbank.sv
// Multi-bank DCCM SECDED checker/corrector with a one-entry correction write-back
// buffer and saturating single/double error statistics.
module el2_lsu_ecc_mbank #(
    parameter int unsigned NUM_BANKS  = 2,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned CNT_WIDTH  = 16,
    parameter int unsigned PIPE_STAGE = 1
) (
    input  logic                    clk,
    input  logic                    rst_l,
    input  logic                    ecc_disable,
    input  logic                    rd_valid,
    input  logic [ADDR_WIDTH-1:0]   rd_addr,
    input  logic [NUM_BANKS-1:0]    rd_bank_en,
    input  logic [32*NUM_BANKS-1:0] rd_data,
    input  logic [7*NUM_BANKS-1:0]  rd_ecc,
    output logic                    res_valid,
    output logic [32*NUM_BANKS-1:0] sec_data,
    output logic [NUM_BANKS-1:0]    single_err,
    output logic                    double_err,
    output logic                    wb_valid,
    input  logic                    wb_ready,
    output logic [ADDR_WIDTH-1:0]   wb_addr,
    output logic [NUM_BANKS-1:0]    wb_mask,
    output logic [32*NUM_BANKS-1:0] wb_data,
    output logic [7*NUM_BANKS-1:0]  wb_ecc,
    output logic                    wb_drop,
    input  logic                    cnt_clear,
    input  logic [CNT_WIDTH-1:0]    err_thresh,
    output logic [CNT_WIDTH-1:0]    err_cnt_single,
    output logic [CNT_WIDTH-1:0]    err_cnt_double,
    output logic                    err_thresh_hit
);

    localparam int unsigned DW = 32 * NUM_BANKS;
    localparam int unsigned EW = 7 * NUM_BANKS;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    // Data-bit participation in each Hamming check bit (check bit 5 leftmost).
    localparam logic [5:0][31:0] CHK_MASK = {
        32'hFC00_0000, 32'h03FF_F800, 32'h03FC_07F0,
        32'hE3C3_C78E, 32'h9B33_366D, 32'h56AA_AD5B
    };

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WB   = 1'b1
    } wb_state_e;

    function automatic logic [6:0] ecc_gen(input logic [31:0] d);
        logic [6:0] e;
        e = '0;
        for (int k = 0; k < 6; k++) begin
            e[k] = ^(d & CHK_MASK[k]);
        end
        e[6] = (^d) ^ (^e[5:0]);
        return e;
    endfunction

    logic [DW-1:0]         dec_data_c;
    logic [NUM_BANKS-1:0]  dec_single_c;
    logic [NUM_BANKS-1:0]  dec_double_c;
    logic [31:0]           dec_d;
    logic [6:0]            dec_e;
    logic [6:0]            dec_chk;
    logic [5:0]            dec_bsyn;
    logic [ADDR_WIDTH-1:0] res_addr;

    // Per-bank syndrome check; a single error flips the data bit whose column matches.
    always_comb begin
        dec_data_c   = rd_data;
        dec_single_c = '0;
        dec_double_c = '0;
        dec_d        = '0;
        dec_e        = '0;
        dec_chk      = '0;
        dec_bsyn     = '0;
        for (int i = 0; i < int'(NUM_BANKS); i++) begin
            dec_d = rd_data[32*i +: 32];
            dec_e = rd_ecc[7*i +: 7];
            for (int k = 0; k < 6; k++) begin
                dec_chk[k] = dec_e[k] ^ (^(dec_d & CHK_MASK[k]));
            end
            dec_chk[6] = (^dec_d) ^ (^dec_e);
            if (rd_valid && rd_bank_en[i] && !ecc_disable && (dec_chk != 7'd0)) begin
                if (dec_chk[6]) begin
                    dec_single_c[i] = 1'b1;
                    for (int j = 0; j < 32; j++) begin
                        for (int k = 0; k < 6; k++) begin
                            dec_bsyn[k] = CHK_MASK[k][j];
                        end
                        if (dec_bsyn == dec_chk[5:0]) begin
                            dec_d[j] = ~dec_d[j];
                        end
                    end
                    dec_data_c[32*i +: 32] = dec_d;
                end else begin
                    dec_double_c[i] = 1'b1;
                end
            end
        end
    end

    generate
        if (PIPE_STAGE != 0) begin : g_pipe
            logic                  res_valid_q,  res_valid_d;
            logic [DW-1:0]         sec_data_q,   sec_data_d;
            logic [NUM_BANKS-1:0]  single_err_q, single_err_d;
            logic                  double_err_q, double_err_d;
            logic [ADDR_WIDTH-1:0] res_addr_q,   res_addr_d;

            always_comb begin
                res_valid_d  = rd_valid;
                sec_data_d   = dec_data_c;
                single_err_d = dec_single_c;
                double_err_d = |dec_double_c;
                res_addr_d   = rd_addr;
            end

            always_ff @(posedge clk or negedge rst_l) begin
                if (!rst_l) begin
                    res_valid_q  <= 1'b0;
                    sec_data_q   <= '0;
                    single_err_q <= '0;
                    double_err_q <= 1'b0;
                    res_addr_q   <= '0;
                end else begin
                    res_valid_q  <= res_valid_d;
                    sec_data_q   <= sec_data_d;
                    single_err_q <= single_err_d;
                    double_err_q <= double_err_d;
                    res_addr_q   <= res_addr_d;
                end
            end

            assign res_valid  = res_valid_q;
            assign sec_data   = sec_data_q;
            assign single_err = single_err_q;
            assign double_err = double_err_q;
            assign res_addr   = res_addr_q;
        end else begin : g_comb
            assign res_valid  = rd_valid;
            assign sec_data   = dec_data_c;
            assign single_err = dec_single_c;
            assign double_err = |dec_double_c;
            assign res_addr   = rd_addr;
        end
    endgenerate

    wb_state_e             state_q, state_d;
    logic [ADDR_WIDTH-1:0] wb_addr_q, wb_addr_d;
    logic [NUM_BANKS-1:0]  wb_mask_q, wb_mask_d;
    logic [DW-1:0]         wb_data_q, wb_data_d;
    logic [EW-1:0]         wb_ecc_q, wb_ecc_d;
    logic                  wb_drop_q, wb_drop_d;
    logic [CNT_WIDTH-1:0]  err_cnt_single_q, err_cnt_single_d;
    logic [CNT_WIDTH-1:0]  err_cnt_double_q, err_cnt_double_d;
    logic                  err_thresh_hit_q, err_thresh_hit_d;
    logic                  elig_c;
    logic                  capture_c;
    logic                  drop_evt_c;

    // Write-back buffer control, error counters and threshold flag.
    always_comb begin
        elig_c           = res_valid & (|single_err) & ~double_err;
        capture_c        = 1'b0;
        drop_evt_c       = 1'b0;
        state_d          = state_q;
        wb_addr_d        = wb_addr_q;
        wb_mask_d        = wb_mask_q;
        wb_data_d        = wb_data_q;
        wb_ecc_d         = wb_ecc_q;
        wb_drop_d        = wb_drop_q;
        err_cnt_single_d = err_cnt_single_q;
        err_cnt_double_d = err_cnt_double_q;
        err_thresh_hit_d = err_thresh_hit_q;

        case (state_q)
            ST_IDLE: begin
                if (elig_c) begin
                    capture_c = 1'b1;
                    state_d   = ST_WB;
                end
            end
            ST_WB: begin
                if (wb_ready) begin
                    if (elig_c) begin
                        capture_c = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (elig_c) begin
                    drop_evt_c = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (capture_c) begin
            wb_addr_d = res_addr;
            wb_mask_d = single_err;
            wb_data_d = sec_data;
            for (int i = 0; i < int'(NUM_BANKS); i++) begin
                wb_ecc_d[7*i +: 7] = ecc_gen(sec_data[32*i +: 32]);
            end
        end

        if (cnt_clear) begin
            err_cnt_single_d = '0;
            err_cnt_double_d = '0;
            err_thresh_hit_d = 1'b0;
            wb_drop_d        = 1'b0;
        end else begin
            if (elig_c && (err_cnt_single_q != CNT_MAX)) begin
                err_cnt_single_d = err_cnt_single_q + CNT_WIDTH'(1);
            end
            if (res_valid && double_err && (err_cnt_double_q != CNT_MAX)) begin
                err_cnt_double_d = err_cnt_double_q + CNT_WIDTH'(1);
            end
            err_thresh_hit_d = (err_thresh != '0) && (err_cnt_single_q >= err_thresh);
            wb_drop_d        = wb_drop_q | drop_evt_c;
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q          <= ST_IDLE;
            wb_addr_q        <= '0;
            wb_mask_q        <= '0;
            wb_data_q        <= '0;
            wb_ecc_q         <= '0;
            wb_drop_q        <= 1'b0;
            err_cnt_single_q <= '0;
            err_cnt_double_q <= '0;
            err_thresh_hit_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            wb_addr_q        <= wb_addr_d;
            wb_mask_q        <= wb_mask_d;
            wb_data_q        <= wb_data_d;
            wb_ecc_q         <= wb_ecc_d;
            wb_drop_q        <= wb_drop_d;
            err_cnt_single_q <= err_cnt_single_d;
            err_cnt_double_q <= err_cnt_double_d;
            err_thresh_hit_q <= err_thresh_hit_d;
        end
    end

    assign wb_valid       = (state_q == ST_WB);
    assign wb_addr        = wb_addr_q;
    assign wb_mask        = wb_mask_q;
    assign wb_data        = wb_data_q;
    assign wb_ecc         = wb_ecc_q;
    assign wb_drop        = wb_drop_q;
    assign err_cnt_single = err_cnt_single_q;
    assign err_cnt_double = err_cnt_double_q;
    assign err_thresh_hit = err_thresh_hit_q;

endmodule

// File: tb/tb_el2_lsu_ecc_mbank.sv
// Randomized bench for el2_lsu_ecc_mbank against a codeword-position Hamming model
// and an abstract one-slot write-back buffer model.
module tb_el2_lsu_ecc_mbank;

    localparam int unsigned NB = 2;
    localparam int unsigned AW = 16;
    localparam int unsigned CW = 16;

    logic          clk = 1'b0;
    logic          rst_l;
    logic          ecc_disable;
    logic          rd_valid;
    logic [AW-1:0] rd_addr;
    logic [NB-1:0] rd_bank_en;
    logic [63:0]   rd_data;
    logic [13:0]   rd_ecc;
    logic          res_valid;
    logic [63:0]   sec_data;
    logic [NB-1:0] single_err;
    logic          double_err;
    logic          wb_valid;
    logic          wb_ready;
    logic [AW-1:0] wb_addr;
    logic [NB-1:0] wb_mask;
    logic [63:0]   wb_data;
    logic [13:0]   wb_ecc;
    logic          wb_drop;
    logic          cnt_clear;
    logic [CW-1:0] err_thresh;
    logic [CW-1:0] err_cnt_single;
    logic [CW-1:0] err_cnt_double;
    logic          err_thresh_hit;

    el2_lsu_ecc_mbank #(
        .NUM_BANKS (NB),
        .ADDR_WIDTH(AW),
        .CNT_WIDTH (CW),
        .PIPE_STAGE(1)
    ) dut (
        .clk           (clk),
        .rst_l         (rst_l),
        .ecc_disable   (ecc_disable),
        .rd_valid      (rd_valid),
        .rd_addr       (rd_addr),
        .rd_bank_en    (rd_bank_en),
        .rd_data       (rd_data),
        .rd_ecc        (rd_ecc),
        .res_valid     (res_valid),
        .sec_data      (sec_data),
        .single_err    (single_err),
        .double_err    (double_err),
        .wb_valid      (wb_valid),
        .wb_ready      (wb_ready),
        .wb_addr       (wb_addr),
        .wb_mask       (wb_mask),
        .wb_data       (wb_data),
        .wb_ecc        (wb_ecc),
        .wb_drop       (wb_drop),
        .cnt_clear     (cnt_clear),
        .err_thresh    (err_thresh),
        .err_cnt_single(err_cnt_single),
        .err_cnt_double(err_cnt_double),
        .err_thresh_hit(err_thresh_hit)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", tag, act, exp);
    endtask

    function automatic bit is_pow2(input int p);
        return (p & (p - 1)) == 0;
    endfunction

    // Check bits sit at codeword positions 1,2,4,..,32; data fills the rest of 1..38.
    function automatic logic [6:0] ref_encode(input logic [31:0] d);
        int syn;
        int di;
        int ones;
        logic [6:0] e;
        syn = 0; di = 0; ones = 0;
        for (int p = 1; p <= 38; p++) begin
            if (!is_pow2(p)) begin
                if (d[di]) begin
                    syn = syn ^ p;
                    ones++;
                end
                di++;
            end
        end
        e[5:0] = 6'(syn);
        ones = ones + $countones(e[5:0]);
        e[6] = ones[0];
        return e;
    endfunction

    task automatic ref_decode(input logic [31:0] d, input logic [6:0] e, input bit en,
                              output logic [31:0] dout, output bit se, output bit de);
        logic [39:0] cw;
        int syn;
        int di;
        int k;
        bit par;
        cw = '0; syn = 0; di = 0; k = 0;
        for (int p = 1; p <= 38; p++) begin
            if (is_pow2(p)) begin
                cw[p] = e[k];
                k++;
            end else begin
                cw[p] = d[di];
                di++;
            end
        end
        for (int p = 1; p <= 38; p++) if (cw[p]) syn = syn ^ p;
        par = (^cw) ^ e[6];
        se = 1'b0; de = 1'b0; dout = d;
        if (en) begin
            if (par) begin
                se = 1'b1;
                if (syn >= 1 && syn <= 38) cw[syn] = ~cw[syn];
                di = 0;
                for (int p = 1; p <= 38; p++) begin
                    if (!is_pow2(p)) begin
                        dout[di] = cw[p];
                        di++;
                    end
                end
            end else if (syn != 0) begin
                de = 1'b1;
            end
        end
    endtask

    // Reference state: visible outputs after the most recent clock edge.
    logic          m_res_valid, m_double, m_wb_valid, m_drop, m_hit;
    logic [63:0]   m_sec_data, m_wb_data;
    logic [NB-1:0] m_single, m_wb_mask;
    logic [AW-1:0] m_res_addr, m_wb_addr;
    logic [13:0]   m_wb_ecc;
    logic [CW-1:0] m_cs, m_cd;

    task automatic model_reset();
        m_res_valid = 0; m_double = 0; m_wb_valid = 0; m_drop = 0; m_hit = 0;
        m_sec_data = '0; m_wb_data = '0; m_single = '0; m_wb_mask = '0;
        m_res_addr = '0; m_wb_addr = '0; m_wb_ecc = '0; m_cs = '0; m_cd = '0;
    endtask

    task automatic model_step();
        bit elig;
        logic [CW-1:0] cs_old;
        logic [31:0] dout;
        bit se;
        bit de;
        elig   = m_res_valid && (m_single != '0) && !m_double;
        cs_old = m_cs;
        if (!m_wb_valid || wb_ready) begin
            m_wb_valid = elig;
            if (elig) begin
                m_wb_addr = m_res_addr;
                m_wb_mask = m_single;
                m_wb_data = m_sec_data;
                for (int b = 0; b < int'(NB); b++)
                    m_wb_ecc[7*b +: 7] = ref_encode(m_sec_data[32*b +: 32]);
            end
        end else if (elig) begin
            m_drop = 1'b1;
        end
        if (cnt_clear) begin
            m_cs = '0; m_cd = '0; m_drop = 1'b0; m_hit = 1'b0;
        end else begin
            if (elig && m_cs != 16'hFFFF) m_cs = m_cs + 16'd1;
            if (m_double && m_cd != 16'hFFFF) m_cd = m_cd + 16'd1;
            m_hit = (err_thresh != '0) && (cs_old >= err_thresh);
        end
        m_res_valid = rd_valid;
        m_res_addr  = rd_addr;
        m_double    = 1'b0;
        for (int b = 0; b < int'(NB); b++) begin
            ref_decode(rd_data[32*b +: 32], rd_ecc[7*b +: 7],
                       rd_valid && rd_bank_en[b] && !ecc_disable, dout, se, de);
            m_sec_data[32*b +: 32] = dout;
            m_single[b] = se;
            m_double = m_double | de;
        end
    endtask

    task automatic check_outputs();
        chk("res_valid", 64'(res_valid), 64'(m_res_valid));
        chk("sec_data", sec_data, m_sec_data);
        chk("single_err", 64'(single_err), 64'(m_single));
        chk("double_err", 64'(double_err), 64'(m_double));
        chk("wb_valid", 64'(wb_valid), 64'(m_wb_valid));
        if (m_wb_valid) begin
            chk("wb_addr", 64'(wb_addr), 64'(m_wb_addr));
            chk("wb_mask", 64'(wb_mask), 64'(m_wb_mask));
            chk("wb_data", wb_data, m_wb_data);
            chk("wb_ecc", 64'(wb_ecc), 64'(m_wb_ecc));
        end
        chk("wb_drop", 64'(wb_drop), 64'(m_drop));
        chk("err_cnt_single", 64'(err_cnt_single), 64'(m_cs));
        chk("err_cnt_double", 64'(err_cnt_double), 64'(m_cd));
        chk("err_thresh_hit", 64'(err_thresh_hit), 64'(m_hit));
    endtask

    // Inputs are set by the caller; advance one edge and compare everything.
    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic set_idle(input logic rdy);
        rd_valid = 0; rd_addr = '0; rd_bank_en = '0; rd_data = '0; rd_ecc = '0;
        wb_ready = rdy;
    endtask

    task automatic set_acc(input logic [AW-1:0] a, input logic [63:0] d, input logic rdy);
        rd_valid = 1; rd_addr = a; rd_bank_en = 2'b11; rd_data = d; rd_ecc = '0;
        wb_ready = rdy;
    endtask

    task automatic rand_inputs();
        logic [31:0] d;
        logic [6:0] e;
        int n;
        int idx;
        rd_valid    = ($urandom_range(0, 3) != 0);
        rd_addr     = 16'($urandom);
        rd_bank_en  = 2'($urandom);
        wb_ready    = ($urandom_range(0, 2) != 0);
        ecc_disable = ($urandom_range(0, 15) == 0);
        cnt_clear   = ($urandom_range(0, 49) == 0);
        err_thresh  = 16'($urandom_range(0, 8));
        for (int b = 0; b < int'(NB); b++) begin
            d = $urandom;
            e = ref_encode(d);
            n = $urandom_range(0, 9);
            if (n >= 7) begin
                idx = $urandom_range(0, 38);
                if (idx < 32) d[idx] = ~d[idx]; else e[idx-32] = ~e[idx-32];
                if (n == 9) begin
                    idx = (idx + $urandom_range(1, 38)) % 39;
                    if (idx < 32) d[idx] = ~d[idx]; else e[idx-32] = ~e[idx-32];
                end
            end
            rd_data[32*b +: 32] = d;
            rd_ecc[7*b +: 7]    = e;
        end
    endtask

    initial begin
        rst_l = 0; ecc_disable = 0; cnt_clear = 0; err_thresh = '0;
        set_idle(0);
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_l = 1;
        step();

        // clean access
        set_acc(16'h0010, 64'h0, 0); step();
        chk("t1_res_valid", 64'(res_valid), 64'd1);
        chk("t1_single", 64'(single_err), 64'd0);
        chk("t1_double", 64'(double_err), 64'd0);

        // single error in bank1, held write-back
        set_acc(16'h0020, {32'h1, 32'h0}, 0); step();
        chk("t2_sec_data", sec_data, 64'h0);
        chk("t2_single", 64'(single_err), 64'd2);
        set_idle(0); step();
        chk("t2_cnt_single", 64'(err_cnt_single), 64'd1);
        chk("t2_wb_valid", 64'(wb_valid), 64'd1);
        chk("t2_wb_mask", 64'(wb_mask), 64'd2);
        chk("t2_wb_data", wb_data, 64'h0);
        chk("t2_wb_ecc", 64'(wb_ecc), 64'd0);
        step();
        chk("t2_hold_valid", 64'(wb_valid), 64'd1);
        chk("t2_hold_addr", 64'(wb_addr), 64'h20);
        wb_ready = 1; step();
        chk("t2_done", 64'(wb_valid), 64'd0);

        // double error in bank0
        set_acc(16'h0030, {32'h0, 32'h3}, 0); step();
        chk("t3_double", 64'(double_err), 64'd1);
        set_idle(0); step();
        chk("t3_cnt_double", 64'(err_cnt_double), 64'd1);
        chk("t3_cnt_single", 64'(err_cnt_single), 64'd1);
        chk("t3_no_wb", 64'(wb_valid), 64'd0);

        // drop while blocked, then capture on the handshake edge
        set_acc(16'h0041, {32'h0, 32'h1}, 0); step();
        set_idle(0); step();
        chk("t4_first", 64'(wb_addr), 64'h41);
        set_acc(16'h0042, {32'h0, 32'h1}, 0); step();
        set_acc(16'h0043, {32'h0, 32'h1}, 0); step();
        chk("t4_drop", 64'(wb_drop), 64'd1);
        chk("t4_kept_addr", 64'(wb_addr), 64'h41);
        set_idle(1); step();
        chk("t4_back2back_valid", 64'(wb_valid), 64'd1);
        chk("t4_back2back_addr", 64'(wb_addr), 64'h43);
        step();

        // threshold flag and clear
        cnt_clear = 1; step(); cnt_clear = 0;
        chk("t5_clr_cnt", 64'(err_cnt_single), 64'd0);
        chk("t5_clr_drop", 64'(wb_drop), 64'd0);
        err_thresh = 16'd3;
        for (int i = 0; i < 3; i++) begin
            set_acc(16'h0050 + 16'(i), {32'h0, 32'h1}, 1); step();
        end
        set_idle(1); step();
        chk("t5_cnt3", 64'(err_cnt_single), 64'd3);
        chk("t5_hit_late", 64'(err_thresh_hit), 64'd0);
        step();
        chk("t5_hit", 64'(err_thresh_hit), 64'd1);
        cnt_clear = 1; step(); cnt_clear = 0;
        chk("t5_clr_hit", 64'(err_thresh_hit), 64'd0);
        chk("t5_clr_cnt2", 64'(err_cnt_single), 64'd0);

        // ecc_disable passes raw data with no error or count
        ecc_disable = 1;
        set_acc(16'h0060, {32'h1, 32'h0}, 1); step();
        chk("t6_single", 64'(single_err), 64'd0);
        chk("t6_raw", sec_data, {32'h1, 32'h0});
        set_idle(1); step();
        chk("t6_cnt", 64'(err_cnt_single), 64'd0);
        ecc_disable = 0;

        // async reset abandons a pending write-back
        set_acc(16'h0070, {32'h0, 32'h1}, 0); step();
        set_idle(0); step();
        chk("t7_pending", 64'(wb_valid), 64'd1);
        #2 rst_l = 0;
        #1;
        chk("t7_rst_wb_valid", 64'(wb_valid), 64'd0);
        chk("t7_rst_cnt", 64'(err_cnt_single), 64'd0);
        model_reset();
        @(negedge clk);
        rst_l = 1;
        step();

        for (int c = 0; c < 2500; c++) begin
            rand_inputs();
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
